// File: rtl/rv_seq_alu.sv
// Multi-cycle RV32I/M execute ALU: base ops finish in one cycle, multiply and
// divide iterate one bit per cycle on operand magnitudes, then sign-fix.
module rv_seq_alu #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      funct3,
  input  logic            op_sign,
  input  logic            m_ext,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            overflow,
  output logic            done
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mag_q, mag_d;
  logic                neg_q, neg_d, div_q, div_d;
  logic [1:0]          f3_q, f3_d;
  logic                load, ovf_d;
  logic [XLEN-1:0]     res_d;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic add_sub_ovf(input logic sa, input logic sb, input logic sr,
                                       input logic sub);
    return (sa == (sb ^ sub)) && (sr != sa);
  endfunction

  // Single-cycle base group
  logic signed [XLEN-1:0] a_s, b_s, sra_v;
  logic [XLEN-1:0]        sum_v, base_res;
  logic                   base_ovf;
  logic [SHW-1:0]         sh;

  always_comb begin
    a_s      = op_a;
    b_s      = op_b;
    sh       = op_b[SHW-1:0];
    sum_v    = op_sign ? op_a - op_b : op_a + op_b;
    sra_v    = a_s >>> sh;
    base_ovf = 1'b0;
    case (funct3)
      3'b000: begin
        base_res = sum_v;
        base_ovf = add_sub_ovf(op_a[XLEN-1], op_b[XLEN-1], sum_v[XLEN-1], op_sign);
      end
      3'b001:  base_res = op_a << sh;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, a_s < b_s};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'b100:  base_res = op_a ^ op_b;
      3'b101:  base_res = op_sign ? sra_v : op_a >> sh;
      3'b110:  base_res = op_a | op_b;
      default: base_res = op_a & op_b;
    endcase
  end

  // Operand sign/magnitude split for the iterative group
  logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn    = m_ext && (funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10));
    b_sgn    = m_ext && (funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01));
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_mag    = neg_if(a_neg, op_a);
    b_mag    = neg_if(b_neg, op_b);
    div_zero = (op_b == '0);
    div_ovf  = !funct3[0] && (op_a == MIN_VAL) && (op_b == '1);
  end

  // Iteration step datapath
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mag_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    div_sel   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    div_d   = div_q;
    f3_d    = f3_q;
    load    = 1'b0;
    res_d   = base_res;
    ovf_d   = 1'b0;
    ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_DIV: begin
        // restoring step: keep the trial remainder only when it did not borrow
        acc_d = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        load    = 1'b1;
        res_d   = div_q ? neg_if(neg_q, div_sel)
                        : (f3_q == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
    if (start && ready) begin
      f3_d  = funct3[1:0];
      div_d = funct3[2];
      if (!m_ext) begin
        load    = 1'b1;
        res_d   = base_res;
        ovf_d   = base_ovf;
        state_d = S_DONE;
      end else if (funct3[2] && (div_zero || div_ovf)) begin
        load    = 1'b1;
        ovf_d   = div_ovf;
        res_d   = funct3[1] ? (div_zero ? op_a : '0) : (div_zero ? '1 : MIN_VAL);
        state_d = S_DONE;
      end else begin
        state_d = funct3[2] ? S_DIV : S_MUL;
        cnt_d   = SHW'(XLEN-1);
        mag_d   = funct3[2] ? b_mag : a_mag;
        acc_d   = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
        // remainder follows the dividend; product and quotient follow the sign xor
        neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        result   <= res_d;
        zero     <= (res_d == '0);
        negative <= res_d[XLEN-1];
        overflow <= ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    mag_q <= mag_d;
    neg_q <= neg_d;
    div_q <= div_d;
    f3_q  <= f3_d;
  end

endmodule
